// File: rtl/async_fifo.sv
// async_fifo: single-clock DEPTH x DATA_WIDTH FIFO with the legacy Async_FIFO
// port set. Pointers carry one extra wrap bit so full and empty can be told
// apart when the low index bits are equal.
module async_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  w_en,
  input  logic                  r_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  full,
  output logic                  empty
);

  localparam int ADDR_WIDTH = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_WIDTH:0]   r_wptr;
  logic [ADDR_WIDTH:0]   r_rptr;
  logic [DATA_WIDTH-1:0] r_data_out;

  logic                  w_full;
  logic                  w_empty;
  logic                  w_wr_ok;
  logic                  w_rd_ok;
  logic [ADDR_WIDTH-1:0] w_waddr;
  logic [ADDR_WIDTH-1:0] w_raddr;
  logic [ADDR_WIDTH:0]   w_ptr_one;

  assign w_ptr_one = {{ADDR_WIDTH{1'b0}}, 1'b1};
  assign w_waddr   = r_wptr[ADDR_WIDTH-1:0];
  assign w_raddr   = r_rptr[ADDR_WIDTH-1:0];

  // Flags decoded from the registered pointers; each side is then qualified by them.
  always_comb begin
    w_empty = (r_wptr == r_rptr);
    w_full  = (r_wptr[ADDR_WIDTH] != r_rptr[ADDR_WIDTH]) &&
              (r_wptr[ADDR_WIDTH-1:0] == r_rptr[ADDR_WIDTH-1:0]);
    w_wr_ok = w_en && !w_full;
    w_rd_ok = r_en && !w_empty;
  end

  // Storage write; contents deliberately survive reset since pointers gate visibility.
  always_ff @(posedge clk) begin
    if (w_wr_ok && !rst) begin
      r_mem[w_waddr] <= data_in;
    end
  end

  // Write pointer: advances once per accepted write, wraps modulo 2*DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr <= {(ADDR_WIDTH+1){1'b0}};
    end else if (w_wr_ok) begin
      r_wptr <= r_wptr + w_ptr_one;
    end else begin
      r_wptr <= r_wptr;
    end
  end

  // Read pointer and registered read data; data_out holds when no read is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rptr     <= {(ADDR_WIDTH+1){1'b0}};
      r_data_out <= {DATA_WIDTH{1'b0}};
    end else if (w_rd_ok) begin
      r_rptr     <= r_rptr + w_ptr_one;
      r_data_out <= r_mem[w_raddr];
    end else begin
      r_rptr     <= r_rptr;
      r_data_out <= r_data_out;
    end
  end

  assign data_out = r_data_out;
  assign full     = w_full;
  assign empty    = w_empty;

endmodule

// File: tb/tb_async_fifo.sv
// Self-checking bench for async_fifo: directed scenarios plus random traffic,
// all compared against a queue-based reference model.
module tb_async_fifo;

  localparam int DW    = 8;
  localparam int DEPTH = 8;

  logic          clk;
  logic          rst;
  logic          w_en;
  logic          r_en;
  logic [DW-1:0] data_in;
  logic [DW-1:0] data_out;
  logic          full;
  logic          empty;

  int n_checks;
  int n_fail;

  logic [DW-1:0] model_q[$];
  logic [DW-1:0] model_dout;

  async_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .w_en     (w_en),
    .r_en     (r_en),
    .data_in  (data_in),
    .data_out (data_out),
    .full     (full),
    .empty    (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  // One clock: drive on the falling edge, update the model at the rising edge,
  // then compare flags and data shortly after.
  task automatic step(input logic s_rst, input logic s_w, input logic s_r,
                      input logic [DW-1:0] s_d);
    bit wr_ok;
    bit rd_ok;
    @(negedge clk);
    rst     = s_rst;
    w_en    = s_w;
    r_en    = s_r;
    data_in = s_d;
    @(posedge clk);
    if (s_rst) begin
      model_q.delete();
      model_dout = '0;
    end else begin
      wr_ok = s_w && (model_q.size() < DEPTH);
      rd_ok = s_r && (model_q.size() > 0);
      if (rd_ok) model_dout = model_q.pop_front();
      if (wr_ok) model_q.push_back(s_d);
    end
    #1;
    check_value("empty", 32'(empty), 32'(model_q.size() == 0));
    check_value("full", 32'(full), 32'(model_q.size() == DEPTH));
    check_value("data_out", 32'(data_out), 32'(model_dout));
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    model_dout = '0;
    rst = 1'b1; w_en = 1'b0; r_en = 1'b0; data_in = '0;

    // 1. reset with both enables high
    step(1'b1, 1'b1, 1'b1, 8'hAA);
    step(1'b1, 1'b1, 1'b1, 8'h55);
    check_value("reset_empty", 32'(empty), 32'd1);
    check_value("reset_full", 32'(full), 32'd0);
    check_value("reset_dout", 32'(data_out), 32'd0);

    // 2. fill with 1..8, then attempt overflow with 9
    for (int i = 1; i <= 8; i++) begin
      step(1'b0, 1'b1, 1'b0, 8'(i));
      if (i == 1) check_value("fill_first_not_empty", 32'(empty), 32'd0);
    end
    check_value("fill_full", 32'(full), 32'd1);
    step(1'b0, 1'b1, 1'b0, 8'd9);
    check_value("overflow_full", 32'(full), 32'd1);

    // 3. drain 9 times; ninth read is ignored
    for (int i = 1; i <= 9; i++) begin
      step(1'b0, 1'b0, 1'b1, 8'h00);
      if (i <= 8) check_value("drain_order", 32'(data_out), 32'(i));
      if (i == 1) check_value("drain_full_clear", 32'(full), 32'd0);
    end
    check_value("drain_empty", 32'(empty), 32'd1);
    check_value("underflow_hold", 32'(data_out), 32'd8);

    // 4. simultaneous read/write at occupancy 4
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 8'(10 + i));
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 1'b1, 8'(20 + i));
      check_value("simul_dout", 32'(data_out), 32'(10 + i));
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 1'b1, 8'h00);
      check_value("simul_tail", 32'(data_out), 32'(20 + i));
    end

    // 5. wrap: 20 write/read pairs at occupancy 1
    step(1'b0, 1'b1, 1'b0, 8'd100);
    for (int i = 1; i <= 20; i++) step(1'b0, 1'b1, 1'b1, 8'(100 + i));
    step(1'b0, 1'b0, 1'b1, 8'h00);
    check_value("wrap_last", 32'(data_out), 32'd120);
    check_value("wrap_empty", 32'(empty), 32'd1);

    // 6a. full with both enables: read accepted, write dropped
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0, 8'(50 + i));
    step(1'b0, 1'b1, 1'b1, 8'hEE);
    check_value("fullrw_dout", 32'(data_out), 32'd50);
    check_value("fullrw_not_full", 32'(full), 32'd0);
    for (int i = 0; i < 7; i++) step(1'b0, 1'b0, 1'b1, 8'h00);
    check_value("fullrw_dropped", 32'(data_out), 32'd57);
    check_value("fullrw_empty", 32'(empty), 32'd1);

    // 6b. reset with 5 entries stored
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 8'(70 + i));
    step(1'b1, 1'b0, 1'b0, 8'h00);
    check_value("midrst_empty", 32'(empty), 32'd1);
    check_value("midrst_full", 32'(full), 32'd0);
    check_value("midrst_dout", 32'(data_out), 32'd0);

    // Random traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 99) == 0), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 8'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Overall time bound so the bench can never hang
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
    $fatal(1, "timeout");
  end

endmodule
